transmission8_reg: RTL and testbench



---
 rtl/transmission_pkg.sv | 16 +
 rtl/transmission_sel8.sv | 23 ++
 rtl/transmission8_reg.sv | 46 ++++
 tb/tb_transmission8_reg.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/transmission_pkg.sv
// transmission_pkg: shared widths, idle level and types for the 8-channel
// select/distribute datapath.
`default_nettype none

package transmission_pkg;

  localparam int   DATA_W   = 8;
  localparam int   SEL_W    = 3;
  localparam logic IDLE_VAL = 1'b1;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [SEL_W-1:0]  sel_t;

endpackage

`default_nettype wire

// File: rtl/transmission_sel8.sv
// transmission_sel8: combinational 8:1 selector feeding a 1:8 distributor.
// The selected source bit lands on the same output lane; other lanes idle.
`default_nettype none

module transmission_sel8
  import transmission_pkg::*;
(
  input  data_t data_in,
  input  sel_t  sel,
  output data_t next_data
);

  logic sel_bit;

  always_comb begin
    sel_bit   = data_in[sel];
    next_data = {DATA_W{IDLE_VAL}};
    next_data[sel] = sel_bit;
  end

endmodule

`default_nettype wire

// File: rtl/transmission8_reg.sv
// transmission8_reg: registered select/distribute path with a one-cycle
// valid strobe; asynchronous active-low reset drives all lanes idle.
`default_nettype none

module transmission8_reg
  import transmission_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] iData,
  input  logic              A,
  input  logic              B,
  input  logic              C,
  input  logic              iValid,
  output logic [DATA_W-1:0] oData,
  output logic              oValid
);

  sel_t  sel;
  data_t next_data;

  assign sel = {A, B, C};

  transmission_sel8 u_sel8 (
    .data_in   (iData),
    .sel       (sel),
    .next_data (next_data)
  );

  // Inputs are only consumed when iValid is high, so X on idle cycles never
  // reaches the registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oData  <= {DATA_W{IDLE_VAL}};
      oValid <= 1'b0;
    end else begin
      oValid <= iValid;
      if (iValid) begin
        oData <= next_data;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_transmission8_reg.sv
// tb_transmission8_reg: directed self-checking bench for transmission8_reg.
`timescale 1ns/1ps
`default_nettype none

module tb_transmission8_reg;

  logic       clk;
  logic       rst_n;
  logic [7:0] iData;
  logic       A, B, C;
  logic       iValid;
  logic [7:0] oData;
  logic       oValid;

  int total;
  int bad;

  transmission8_reg dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .iData  (iData),
    .A      (A),
    .B      (B),
    .C      (C),
    .iValid (iValid),
    .oData  (oData),
    .oValid (oValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs at the falling edge, then sample 1ns after the next rise.
  task automatic drive(input logic [7:0] d, input logic [2:0] s, input logic v);
    @(negedge clk);
    iData  = d;
    {A, B, C} = s;
    iValid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    drive(8'h00, 3'd0, 1'b1);
    total++;
    if (oData !== 8'hFE || oValid !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_load oData=%h oValid=%b want FE/1", oData, oValid);
    end
    // Assert reset mid-cycle, well away from any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (oData !== 8'hFF || oValid !== 1'b0) begin
      bad++;
      $display("FAIL async_reset oData=%h oValid=%b want FF/0", oData, oValid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    iValid = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (oData !== 8'hFF || oValid !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_idle oData=%h oValid=%b want FF/0", oData, oValid);
    end
  endtask

  task automatic test_walking_zero;
    logic [7:0] exp_tab [8];
    exp_tab = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    for (int i = 0; i < 8; i++) begin
      drive(8'h00, 3'(i), 1'b1);
      total++;
      if (oData !== exp_tab[i] || oValid !== 1'b1) begin
        bad++;
        $display("FAIL walking_zero sel=%0d oData=%h oValid=%b want %h/1",
                 i, oData, oValid, exp_tab[i]);
      end
    end
  endtask

  task automatic test_all_ones;
    logic [2:0] sels [3];
    sels = '{3'd0, 3'd3, 3'd7};
    for (int i = 0; i < 3; i++) begin
      drive(8'hFF, sels[i], 1'b1);
      total++;
      if (oData !== 8'hFF || oValid !== 1'b1) begin
        bad++;
        $display("FAIL all_ones sel=%0d oData=%h oValid=%b want FF/1",
                 sels[i], oData, oValid);
      end
    end
  endtask

  task automatic test_mixed;
    logic [2:0] sels [4];
    logic [7:0] exp_tab [4];
    sels    = '{3'b010, 3'b001, 3'b110, 3'b111};
    exp_tab = '{8'hFF,  8'hFD,  8'hBF,  8'hFF};
    for (int i = 0; i < 4; i++) begin
      drive(8'hA5, sels[i], 1'b1);
      total++;
      if (oData !== exp_tab[i] || oValid !== 1'b1) begin
        bad++;
        $display("FAIL mixed_a5 sel=%b oData=%h oValid=%b want %h/1",
                 sels[i], oData, oValid, exp_tab[i]);
      end
    end
  endtask

  task automatic test_hold;
    drive(8'h00, 3'd3, 1'b1);
    total++;
    if (oData !== 8'hF7 || oValid !== 1'b1) begin
      bad++;
      $display("FAIL hold_load oData=%h oValid=%b want F7/1", oData, oValid);
    end
    drive(8'h12, 3'd0, 1'b0);
    total++;
    if (oData !== 8'hF7 || oValid !== 1'b0) begin
      bad++;
      $display("FAIL hold_c1 oData=%h oValid=%b want F7/0", oData, oValid);
    end
    drive(8'hxx, 3'bxxx, 1'b0);
    total++;
    if (oData !== 8'hF7 || oValid !== 1'b0) begin
      bad++;
      $display("FAIL hold_c2 oData=%h oValid=%b want F7/0", oData, oValid);
    end
    drive(8'h00, 3'd5, 1'b0);
    total++;
    if (oData !== 8'hF7 || oValid !== 1'b0) begin
      bad++;
      $display("FAIL hold_c3 oData=%h oValid=%b want F7/0", oData, oValid);
    end
  endtask

  task automatic test_reset_midstream;
    logic [7:0] exp_tab [4];
    exp_tab = '{8'hFE, 8'hFD, 8'hFB, 8'hF7};
    for (int i = 0; i < 4; i++) begin
      drive(8'h00, 3'(i), 1'b1);
      total++;
      if (oData !== exp_tab[i] || oValid !== 1'b1) begin
        bad++;
        $display("FAIL midstream_pre sel=%0d oData=%h want %h", i, oData, exp_tab[i]);
      end
    end
    // ABC=100 is presented but reset lands before its capture edge.
    @(negedge clk);
    iData = 8'h00;
    {A, B, C} = 3'b100;
    iValid = 1'b1;
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (oData !== 8'hFF || oValid !== 1'b0) begin
      bad++;
      $display("FAIL midstream_reset oData=%h oValid=%b want FF/0", oData, oValid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    {A, B, C} = 3'b101;
    @(posedge clk);
    #1;
    total++;
    if (oData !== 8'hDF || oValid !== 1'b1) begin
      bad++;
      $display("FAIL midstream_first oData=%h oValid=%b want DF/1", oData, oValid);
    end
  endtask

  task automatic test_back_to_back;
    drive(8'h7E, 3'd0, 1'b1);
    total++;
    if (oData !== 8'hFE || oValid !== 1'b1) begin
      bad++;
      $display("FAIL b2b_0 oData=%h oValid=%b want FE/1", oData, oValid);
    end
    drive(8'h7E, 3'd7, 1'b1);
    total++;
    if (oData !== 8'h7F || oValid !== 1'b1) begin
      bad++;
      $display("FAIL b2b_1 oData=%h oValid=%b want 7F/1", oData, oValid);
    end
    drive(8'h7E, 3'd4, 1'b1);
    total++;
    if (oData !== 8'hFF || oValid !== 1'b1) begin
      bad++;
      $display("FAIL b2b_2 oData=%h oValid=%b want FF/1", oData, oValid);
    end
    drive(8'h7E, 3'd4, 1'b0);
    total++;
    if (oData !== 8'hFF || oValid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_drop oData=%h oValid=%b want FF/0", oData, oValid);
    end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    rst_n  = 1'b0;
    iData  = 8'h00;
    {A, B, C} = 3'b000;
    iValid = 1'b0;
    #12;
    total++;
    if (oData !== 8'hFF || oValid !== 1'b0) begin
      bad++;
      $display("FAIL reset_state oData=%h oValid=%b want FF/0", oData, oValid);
    end
    @(negedge clk);
    rst_n = 1'b1;

    test_reset();
    test_walking_zero();
    test_all_ones();
    test_mixed();
    test_hold();
    test_reset_midstream();
    test_back_to_back();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
